wb_arbiter: RTL and testbench

Writeback arbiter for the out-of-order core. It shares the `NUM_PORTS` physical-register-file write ports among `NUM_REQ` execution-unit result sources. Each cycle it grants up to `NUM_PORTS` requests in round-robin order. It registers the winners onto the writeback bus, which fans out to the phys regfile write port, ROB writeback and issue-queue wakeup.

---
 rtl/wb_arbiter_pkg.sv | 17 +
 rtl/rr_multi_picker.sv | 55 +++++
 rtl/wb_arbiter.sv | 108 ++++++++++
 tb/tb_wb_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and sizes for the writeback arbiter: core width parameters
// and the writeback request payload carried from execution units to the regfile.
package wb_arbiter_pkg;

    localparam int PHYS_REG_WIDTH = 7;
    localparam int ROB_ADDR_WIDTH = 6;
    localparam int DISPATCH_WIDTH = 2;
    localparam int WB_DATA_W      = 32;

    typedef struct packed {
        logic [PHYS_REG_WIDTH-1:0] phys_rd;
        logic [WB_DATA_W-1:0]      data;
        logic [DISPATCH_WIDTH-1:0] bank_addr;
        logic [ROB_ADDR_WIDTH-1:0] rob_addr;
    } wb_req_t;

endpackage

// File: rtl/rr_multi_picker.sv
// Combinational round-robin picker: scans sources from rr_ptr_i and hands the
// first NUM_PORTS valid ones to ports 0..NUM_PORTS-1 in scan order.
module rr_multi_picker #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [PTR_W-1:0]     rr_ptr_i,
    output logic [NUM_REQ-1:0]   gnt_mask_o,
    output logic [NUM_PORTS-1:0] gnt_vld_o,
    output logic [PTR_W-1:0]     gnt_idx_o [NUM_PORTS],
    output logic [PTR_W-1:0]     last_idx_o
);

    // Scan with an explicit modulo compare so non-power-of-2 NUM_REQ wraps correctly.
    always_comb begin
        int n;
        int idx;
        gnt_mask_o = '0;
        gnt_vld_o  = '0;
        last_idx_o = '0;
        n          = 0;
        idx        = 0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            gnt_idx_o[p] = '0;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            for (int s = 0; s < NUM_REQ; s++) begin
                if (s == idx && req_valid_i[s] && n < NUM_PORTS) begin
                    gnt_mask_o[s] = 1'b1;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (p == n) begin
                            gnt_vld_o[p] = 1'b1;
                            gnt_idx_o[p] = PTR_W'(s);
                        end else begin
                            gnt_vld_o[p] = gnt_vld_o[p];
                        end
                    end
                    last_idx_o = PTR_W'(s);
                    n          = n + 1;
                end else begin
                    n = n;
                end
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares NUM_PORTS regfile write ports among NUM_REQ result
// sources round-robin, registering winners onto the writeback bus.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int          NUM_REQ    = 4,
    parameter int          NUM_PORTS  = DISPATCH_WIDTH,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] CNT_INIT   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  wb_req_t              req_data [NUM_REQ],
    output logic [NUM_PORTS-1:0] wb_valid,
    output wb_req_t              wb_data [NUM_PORTS],
    output logic [31:0]          conflict_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_PORTS < 1 || NUM_PORTS > NUM_REQ || DATA_WIDTH != WB_DATA_W) begin : g_param_err
        $error("wb_arbiter: unsupported parameter combination");
    end

    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [NUM_PORTS-1:0] wb_valid_q;
    wb_req_t              wb_data_q [NUM_PORTS];

    logic [NUM_REQ-1:0]   gnt_mask_s;
    logic [NUM_PORTS-1:0] gnt_vld_s;
    logic [PTR_W-1:0]     gnt_idx_s [NUM_PORTS];
    logic [PTR_W-1:0]     last_idx_s;

    rr_multi_picker #(
        .NUM_REQ   (NUM_REQ),
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_picker (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .gnt_mask_o  (gnt_mask_s),
        .gnt_vld_o   (gnt_vld_s),
        .gnt_idx_o   (gnt_idx_s),
        .last_idx_o  (last_idx_s)
    );

    // Grants are suppressed while in reset or flush so no source believes it transferred.
    always_comb begin
        if (rst_n && !flush) begin
            req_ready = gnt_mask_s;
        end else begin
            req_ready = '0;
        end
    end

    // Pointer advance past the last winner and saturating conflict count.
    always_comb begin
        int nvalid;
        nvalid   = 0;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            nvalid = nvalid + int'(req_valid[i]);
        end
        if (!flush && gnt_vld_s[0]) begin
            rr_ptr_d = (last_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx_s + PTR_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        if (!flush && nvalid > NUM_PORTS && cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output register stage; idle ports keep their old payload to avoid toggling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            cnt_q      <= CNT_INIT;
            wb_valid_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                wb_data_q[p] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= flush ? '0 : gnt_vld_s;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!flush && gnt_vld_s[p]) begin
                    wb_data_q[p] <= req_data[gnt_idx_s[p]];
                end else begin
                    wb_data_q[p] <= wb_data_q[p];
                end
            end
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized self-checking bench for wb_arbiter against a scan-order reference model.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int NUM_PORTS = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 flush = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_ready, req_ready_sat;
    wb_req_t              req_data [NUM_REQ];
    logic [NUM_PORTS-1:0] wb_valid, wb_valid_sat;
    wb_req_t              wb_data [NUM_PORTS];
    wb_req_t              wb_data_sat [NUM_PORTS];
    logic [31:0]          conflict_cnt, conflict_cnt_sat;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int                   m_ptr = 0;
    logic [31:0]          m_cnt = 32'd0;
    logic [31:0]          m_cnt_sat = 32'd0;
    logic [NUM_REQ-1:0]   m_ready;
    logic [NUM_PORTS-1:0] m_wbv = '0;
    wb_req_t              m_wbd [NUM_PORTS];

    logic [NUM_REQ-1:0]   nxt_valid = '0;
    wb_req_t              nxt_data [NUM_REQ];

    wb_arbiter #(.NUM_REQ(NUM_REQ), .NUM_PORTS(NUM_PORTS), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .wb_valid(wb_valid), .wb_data(wb_data), .conflict_cnt(conflict_cnt)
    );

    wb_arbiter #(.NUM_REQ(NUM_REQ), .NUM_PORTS(NUM_PORTS), .DATA_WIDTH(32),
                 .CNT_INIT(32'hFFFF_FFFE)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready_sat), .req_data(req_data),
        .wb_valid(wb_valid_sat), .wb_data(wb_data_sat), .conflict_cnt(conflict_cnt_sat)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic wb_req_t rand_req();
        wb_req_t r;
        r.phys_rd   = 7'($urandom);
        r.data      = $urandom;
        r.bank_addr = 2'($urandom);
        r.rob_addr  = 6'($urandom);
        return r;
    endfunction

    // One cycle: drive inputs at negedge, check grants, then check registered outputs.
    task automatic step(input logic rst_v, input logic fl_v);
        int n, last, nv, idx;
        int win [NUM_PORTS];
        @(negedge clk);
        rst_n     = rst_v;
        flush     = fl_v;
        req_valid = nxt_valid;
        for (int i = 0; i < NUM_REQ; i++) req_data[i] = nxt_data[i];
        n = 0; last = -1; nv = 0; m_ready = '0;
        for (int p = 0; p < NUM_PORTS; p++) win[p] = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (m_ptr + k) % NUM_REQ;
            if (nxt_valid[idx]) begin
                nv++;
                if (n < NUM_PORTS) begin
                    m_ready[idx] = 1'b1;
                    win[n] = idx;
                    n++;
                    last = idx;
                end
            end
        end
        if (!rst_v || fl_v) m_ready = '0;
        #1;
        check_eq("req_ready", 64'(req_ready), 64'(m_ready));
        check_eq("req_ready_sat", 64'(req_ready_sat), 64'(m_ready));
        @(posedge clk);
        #1;
        if (!rst_v) begin
            m_ptr = 0; m_cnt = 32'd0; m_cnt_sat = 32'hFFFF_FFFE; m_wbv = '0;
            for (int p = 0; p < NUM_PORTS; p++) m_wbd[p] = '0;
        end else if (fl_v) begin
            m_wbv = '0;
        end else begin
            m_wbv = '0;
            for (int p = 0; p < n; p++) begin
                m_wbv[p] = 1'b1;
                m_wbd[p] = nxt_data[win[p]];
            end
            if (n > 0) m_ptr = (last + 1) % NUM_REQ;
            if (nv > NUM_PORTS) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                if (m_cnt_sat != 32'hFFFF_FFFF) m_cnt_sat = m_cnt_sat + 32'd1;
            end
        end
        check_eq("wb_valid", 64'(wb_valid), 64'(m_wbv));
        check_eq("wb_valid_sat", 64'(wb_valid_sat), 64'(m_wbv));
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (m_wbv[p] || !rst_v) begin
                check_eq($sformatf("wb_data[%0d]", p), 64'(wb_data[p]), 64'(m_wbd[p]));
                check_eq($sformatf("wb_data_sat[%0d]", p), 64'(wb_data_sat[p]), 64'(m_wbd[p]));
            end
        end
        check_eq("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
        check_eq("conflict_cnt_sat", 64'(conflict_cnt_sat), 64'(m_cnt_sat));
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            nxt_data[i] = rand_req();
            req_data[i] = '0;
        end
        for (int p = 0; p < NUM_PORTS; p++) m_wbd[p] = '0;

        // reset with every source requesting
        nxt_valid = 4'b1111;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // continuous all-valid round robin: {0,1}, {2,3}, ...
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NUM_REQ; i++) nxt_data[i] = rand_req();
            step(1'b1, 1'b0);
        end

        // sparse: only src2 with a recognisable payload, pointer moves to 3
        nxt_valid = 4'b0100;
        nxt_data[2].phys_rd = 7'd17;
        nxt_data[2].data    = 32'hDEAD_BEEF;
        step(1'b1, 1'b0);

        // wrap: pointer 3 with {0,3} valid
        nxt_valid = 4'b1001;
        nxt_data[0] = rand_req();
        nxt_data[3] = rand_req();
        step(1'b1, 1'b0);

        // flush cycle, then grants resume
        nxt_valid = 4'b1111;
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // randomized traffic honouring hold-until-transfer
        for (int c = 0; c < 400; c++) begin
            logic rst_v, fl_v;
            rst_v = ($urandom_range(0, 49) != 0);
            fl_v  = ($urandom_range(0, 9) == 0);
            step(rst_v, fl_v);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!nxt_valid[i] || m_ready[i]) begin
                    nxt_valid[i] = ($urandom_range(0, 3) != 0);
                    nxt_data[i]  = rand_req();
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
